// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX pipeline register and operand front end for the 64-bit ALU.
//            Captures decoded ID fields, decodes the ALU op_sel code at
//            capture time, resolves EX/MEM and MEM/WB forwarding for both
//            operands and flags load-use hazards back to ID.
// Ports    : clk, rst_n (sync, active-low)
//            id_*_i          decoded instruction fields from ID
//            stall_i/flush_i downstream hold / kill of EX contents
//            exmem_*_i       EX/MEM writeback forwarding source
//            memwb_*_i       MEM/WB writeback forwarding source
//            src1_o/src2_o/op_sel_o   ALU operands and operation code
//            ex_*_o          registered EX-stage control and store data
//            illegal_op_o    registered decode error
//            load_use_stall_o combinational ID hold request
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic             id_alu_src_i,
    input  logic [1:0]       id_alu_op_i,
    input  logic [2:0]       id_funct3_i,
    input  logic             id_funct7_b5_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             exmem_reg_write_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]  exmem_result_i,
    input  logic             memwb_reg_write_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]  memwb_result_i,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  src1_o,
    output logic [XLEN-1:0]  src2_o,
    output logic [3:0]       op_sel_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [REG_W-1:0] ex_rd_o,
    output logic             ex_reg_write_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic             illegal_op_o,
    output logic             load_use_stall_o
);

    localparam logic [3:0] C_OP_AND = 4'd0;
    localparam logic [3:0] C_OP_OR  = 4'd1;
    localparam logic [3:0] C_OP_ADD = 4'd2;
    localparam logic [3:0] C_OP_SUB = 4'd6;
    localparam logic [3:0] C_OP_SLT = 4'd7;
    localparam logic [3:0] C_OP_NOR = 4'd12;

    // EX-stage state
    logic             ex_valid_q,     ex_valid_d;
    logic [REG_W-1:0] ex_rs1_q,       ex_rs1_d;
    logic [REG_W-1:0] ex_rs2_q,       ex_rs2_d;
    logic [REG_W-1:0] ex_rd_q,        ex_rd_d;
    logic [XLEN-1:0]  ex_rs1_data_q,  ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q,  ex_rs2_data_d;
    logic [XLEN-1:0]  ex_imm_q,       ex_imm_d;
    logic             ex_alu_src_q,   ex_alu_src_d;
    logic [3:0]       op_sel_q,       op_sel_d;
    logic             illegal_q,      illegal_d;
    logic             reg_write_q,    reg_write_d;
    logic             mem_read_q,     mem_read_d;
    logic             mem_write_q,    mem_write_d;

    logic [3:0]       w_op_sel;
    logic             w_illegal;
    logic             w_load_use;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // ALU control decode of the instruction currently in ID
    always_comb begin
        w_op_sel  = C_OP_ADD;
        w_illegal = 1'b0;
        case (id_alu_op_i)
            2'b00: w_op_sel = C_OP_ADD;
            2'b01: w_op_sel = C_OP_SUB;
            2'b11: w_op_sel = C_OP_NOR;
            default: begin
                case (id_funct3_i)
                    // funct7[5] only means SUB for register-register forms
                    3'b000: w_op_sel = (id_funct7_b5_i && !id_alu_src_i) ? C_OP_SUB : C_OP_ADD;
                    3'b111: w_op_sel = C_OP_AND;
                    3'b110: w_op_sel = C_OP_OR;
                    3'b010: w_op_sel = C_OP_SLT;
                    default: begin
                        w_op_sel  = C_OP_ADD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // rs2 of an immediate-form instruction is only a real read for stores
    assign w_load_use = ex_valid_q && mem_read_q && (ex_rd_q != '0) && id_valid_i &&
                        ((id_rs1_i == ex_rd_q) ||
                         ((!id_alu_src_i || id_mem_write_i) && (id_rs2_i == ex_rd_q)));

    // Next-state: flush beats stall, stall beats the load-use bubble
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_alu_src_d  = ex_alu_src_q;
        op_sel_d      = op_sel_q;
        illegal_d     = illegal_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        if (flush_i || (!stall_i && (w_load_use || !id_valid_i))) begin
            // Bubble: kill control only, data fields are left untouched
            ex_valid_d  = 1'b0;
            illegal_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!stall_i) begin
            ex_valid_d    = 1'b1;
            ex_rs1_d      = id_rs1_i;
            ex_rs2_d      = id_rs2_i;
            ex_rd_d       = id_rd_i;
            ex_rs1_data_d = id_rs1_data_i;
            ex_rs2_data_d = id_rs2_data_i;
            ex_imm_d      = id_imm_i;
            ex_alu_src_d  = id_alu_src_i;
            op_sel_d      = w_op_sel;
            illegal_d     = w_illegal;
            reg_write_d   = id_reg_write_i;
            mem_read_d    = id_mem_read_i;
            mem_write_d   = id_mem_write_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_alu_src_q  <= 1'b0;
            op_sel_q      <= '0;
            illegal_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_alu_src_q  <= ex_alu_src_d;
            op_sel_q      <= op_sel_d;
            illegal_q     <= illegal_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards
    always_comb begin
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs1_q))
            w_fwd_rs1 = exmem_result_i;
        else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs1_q))
            w_fwd_rs1 = memwb_result_i;
        else
            w_fwd_rs1 = ex_rs1_data_q;
    end

    always_comb begin
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs2_q))
            w_fwd_rs2 = exmem_result_i;
        else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs2_q))
            w_fwd_rs2 = memwb_result_i;
        else
            w_fwd_rs2 = ex_rs2_data_q;
    end

    assign src1_o           = w_fwd_rs1;
    assign src2_o           = ex_alu_src_q ? ex_imm_q : w_fwd_rs2;
    assign ex_rs2_data_o    = w_fwd_rs2;
    assign op_sel_o         = op_sel_q;
    assign ex_valid_o       = ex_valid_q;
    assign ex_rd_o          = ex_rd_q;
    assign ex_reg_write_o   = reg_write_q;
    assign ex_mem_read_o    = mem_read_q;
    assign ex_mem_write_o   = mem_write_q;
    assign illegal_op_o     = illegal_q;
    assign load_use_stall_o = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Self-checking bench for ex_operand_stage. Directed scenarios use
//            hand-derived constants; the random phase checks against a
//            behavioural model of the EX slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    // {alu_op, funct3, funct7_b5, alu_src, expected op_sel, expected illegal}
    localparam logic [11:0] C_DEC_TBL [13] = '{
        12'b00_000_0_0_0010_0, 12'b01_000_0_0_0110_0, 12'b11_000_0_0_1100_0,
        12'b10_111_0_0_0000_0, 12'b10_110_1_0_0001_0, 12'b10_010_0_0_0111_0,
        12'b10_000_1_1_0010_0, 12'b10_000_0_0_0010_0, 12'b10_000_1_0_0110_0,
        12'b10_001_0_0_0010_1, 12'b10_101_1_0_0010_1, 12'b10_100_0_1_0010_1,
        12'b00_001_0_0_0010_0
    };

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid_i;
    logic [REG_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic [XLEN-1:0]  id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic             id_alu_src_i;
    logic [1:0]       id_alu_op_i;
    logic [2:0]       id_funct3_i;
    logic             id_funct7_b5_i, id_reg_write_i, id_mem_read_i, id_mem_write_i;
    logic             stall_i, flush_i;
    logic             exmem_reg_write_i, memwb_reg_write_i;
    logic [REG_W-1:0] exmem_rd_i, memwb_rd_i;
    logic [XLEN-1:0]  exmem_result_i, memwb_result_i;
    logic             ex_valid_o;
    logic [XLEN-1:0]  src1_o, src2_o, ex_rs2_data_o;
    logic [3:0]       op_sel_o;
    logic [REG_W-1:0] ex_rd_o;
    logic             ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
    logic             illegal_op_o, load_use_stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_src_i(id_alu_src_i), .id_alu_op_i(id_alu_op_i), .id_funct3_i(id_funct3_i),
        .id_funct7_b5_i(id_funct7_b5_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .ex_valid_o(ex_valid_o), .src1_o(src1_o), .src2_o(src2_o), .op_sel_o(op_sel_o),
        .ex_rs2_data_o(ex_rs2_data_o), .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .illegal_op_o(illegal_op_o), .load_use_stall_o(load_use_stall_o)
    );

    // ---------------- behavioural reference of the EX slot ----------------
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]  d1, d2, imm;
        logic             src;
        logic [3:0]       op;
        logic             ill, rw, mr, mw;
    } ex_t;

    ex_t m;

    function automatic logic [4:0] ref_decode(logic [1:0] aop, logic [2:0] f3, logic f7, logic src);
        if (aop == 2'd0) return {1'b0, 4'd2};
        if (aop == 2'd1) return {1'b0, 4'd6};
        if (aop == 2'd3) return {1'b0, 4'd12};
        if (f3 == 3'd0)  return {1'b0, (f7 && !src) ? 4'd6 : 4'd2};
        if (f3 == 3'd7)  return {1'b0, 4'd0};
        if (f3 == 3'd6)  return {1'b0, 4'd1};
        if (f3 == 3'd2)  return {1'b0, 4'd7};
        return {1'b1, 4'd2};
    endfunction

    function automatic logic ref_lus();
        return m.v && m.mr && (m.rd != 0) && id_valid_i &&
               ((id_rs1_i == m.rd) || ((!id_alu_src_i || id_mem_write_i) && (id_rs2_i == m.rd)));
    endfunction

    function automatic logic [XLEN-1:0] ref_fwd(logic [REG_W-1:0] rs, logic [XLEN-1:0] d);
        if (exmem_reg_write_i && exmem_rd_i != 0 && exmem_rd_i == rs) return exmem_result_i;
        if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == rs) return memwb_result_i;
        return d;
    endfunction

    function automatic ex_t ref_next();
        ex_t n;
        logic [4:0] dec;
        n = m;
        if (!rst_n) begin
            n = '0;
        end else if (flush_i || (!stall_i && (ref_lus() || !id_valid_i))) begin
            n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.ill = 1'b0;
        end else if (!stall_i) begin
            dec   = ref_decode(id_alu_op_i, id_funct3_i, id_funct7_b5_i, id_alu_src_i);
            n.v   = 1'b1;
            n.rs1 = id_rs1_i;      n.rs2 = id_rs2_i;      n.rd = id_rd_i;
            n.d1  = id_rs1_data_i; n.d2  = id_rs2_data_i; n.imm = id_imm_i;
            n.src = id_alu_src_i;  n.op  = dec[3:0];      n.ill = dec[4];
            n.rw  = id_reg_write_i; n.mr = id_mem_read_i; n.mw = id_mem_write_i;
        end
        return n;
    endfunction

    // One clock: model follows the inputs present at the edge; returns at negedge
    task automatic tick();
        ex_t nx;
        nx = ref_next();
        @(posedge clk);
        m = nx;
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0;
        id_alu_src_i = 1'b0; id_alu_op_i = 2'b00; id_funct3_i = 3'b000; id_funct7_b5_i = 1'b0;
        id_reg_write_i = 1'b0; id_mem_read_i = 1'b0; id_mem_write_i = 1'b0;
        exmem_reg_write_i = 1'b0; exmem_rd_i = '0; exmem_result_i = '0;
        memwb_reg_write_i = 1'b0; memwb_rd_i = '0; memwb_result_i = '0;
    endtask

    task automatic id_op(input logic [1:0] aop, input logic [2:0] f3, input logic f7, input logic src,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                         input logic rw, input logic mr, input logic mw);
        id_valid_i = 1'b1; id_alu_op_i = aop; id_funct3_i = f3; id_funct7_b5_i = f7;
        id_alu_src_i = src; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
        id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
    endtask

    task automatic rand_id();
        id_valid_i = ($urandom_range(0, 9) != 0);
        id_rs1_i = 5'($urandom_range(0, 7)); id_rs2_i = 5'($urandom_range(0, 7));
        id_rd_i  = 5'($urandom_range(0, 7));
        id_rs1_data_i = {$urandom, $urandom}; id_rs2_data_i = {$urandom, $urandom};
        id_imm_i = {$urandom, $urandom};
        id_alu_src_i = 1'($urandom); id_alu_op_i = 2'($urandom); id_funct3_i = 3'($urandom);
        id_funct7_b5_i = 1'($urandom); id_reg_write_i = 1'($urandom);
        id_mem_read_i = 1'($urandom); id_mem_write_i = 1'($urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        id_op(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({ex_valid_o, src1_o, src2_o, op_sel_o, ex_rs2_data_o, ex_rd_o, ex_reg_write_o,
                 ex_mem_read_o, ex_mem_write_o, illegal_op_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%b src1=%0h src2=%0h op=%0d rd=%0d required all zero",
                         ex_valid_o, src1_o, src2_o, op_sel_o, ex_rd_o);
            end
            n_checks++;
            if (load_use_stall_o !== 1'b0) begin
                n_fail++; $display("FAIL reset_lus: got %b required 0", load_use_stall_o);
            end
        end
        rst_n = 1'b1;
        id_op(2'b00, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd3 || src2_o !== 64'h33) begin
            n_fail++; $display("FAIL first_capture: got valid=%b rd=%0d src2=%0h required 1 3 33",
                               ex_valid_o, ex_rd_o, src2_o);
        end
    endtask

    task automatic test_decode();
        logic [11:0] e;
        set_idle(); tick();
        id_op(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 64'd10, 64'd3, 64'd5, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (op_sel_o !== 4'd6 || src1_o !== 64'd10 || src2_o !== 64'd3) begin
            n_fail++; $display("FAIL decode_sub: got op=%0d src1=%0d src2=%0d required 6 10 3",
                               op_sel_o, src1_o, src2_o);
        end
        id_alu_src_i = 1'b1;
        tick();
        n_checks++;
        if (op_sel_o !== 4'd2 || src2_o !== 64'd5) begin
            n_fail++; $display("FAIL decode_addi: got op=%0d src2=%0d required 2 5", op_sel_o, src2_o);
        end
        for (int i = 0; i < 13; i++) begin
            e = C_DEC_TBL[i];
            id_alu_op_i = e[11:10]; id_funct3_i = e[9:7]; id_funct7_b5_i = e[6]; id_alu_src_i = e[5];
            tick();
            n_checks++;
            if (op_sel_o !== e[4:1] || illegal_op_o !== e[0]) begin
                n_fail++; $display("FAIL decode_tbl%0d: got op=%0d ill=%b required op=%0d ill=%b",
                                   i, op_sel_o, illegal_op_o, e[4:1], e[0]);
            end
        end
    endtask

    task automatic test_forwarding();
        set_idle(); tick();
        id_op(2'b10, 3'b000, 1'b0, 1'b0, 5'd5, 5'd6, 5'd9, 64'h11, 64'h22, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        set_idle();
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd5; exmem_result_i = 64'hAA;
        memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd5; memwb_result_i = 64'hBB;
        #1; n_checks++;
        if (src1_o !== 64'hAA) begin n_fail++; $display("FAIL fwd_exmem_prio: got %0h required aa", src1_o); end
        exmem_reg_write_i = 1'b0;
        #1; n_checks++;
        if (src1_o !== 64'hBB) begin n_fail++; $display("FAIL fwd_memwb: got %0h required bb", src1_o); end
        exmem_reg_write_i = 1'b1; exmem_rd_i = '0; memwb_rd_i = '0;
        #1; n_checks++;
        if (src1_o !== 64'h11) begin n_fail++; $display("FAIL fwd_x0: got %0h required 11", src1_o); end
        exmem_rd_i = 5'd6; exmem_result_i = 64'hCC;
        #1; n_checks++;
        if (src2_o !== 64'hCC || ex_rs2_data_o !== 64'hCC || src1_o !== 64'h11) begin
            n_fail++; $display("FAIL fwd_rs2: got src2=%0h rs2d=%0h src1=%0h required cc cc 11",
                               src2_o, ex_rs2_data_o, src1_o);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle(); tick();
        id_op(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd0, 5'd7, 64'h0, 64'h0, 64'h8, 1'b1, 1'b1, 1'b0);
        tick();
        id_op(2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd7, 5'd8, 64'h1, 64'h2, 64'h0, 1'b1, 1'b0, 1'b0);
        #1; n_checks++;
        if (load_use_stall_o !== 1'b1) begin n_fail++; $display("FAIL lus_rs2: got %b required 1", load_use_stall_o); end
        tick();
        n_checks++;
        if (ex_valid_o !== 1'b0 || ex_reg_write_o !== 1'b0 || ex_mem_read_o !== 1'b0) begin
            n_fail++; $display("FAIL lus_bubble: got valid=%b rw=%b mr=%b required 0 0 0",
                               ex_valid_o, ex_reg_write_o, ex_mem_read_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd8) begin
            n_fail++; $display("FAIL lus_replay: got valid=%b rd=%0d required 1 8", ex_valid_o, ex_rd_o);
        end
        id_op(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd0, 5'd7, 64'h0, 64'h0, 64'h8, 1'b1, 1'b1, 1'b0);
        tick();
        id_op(2'b10, 3'b000, 1'b0, 1'b1, 5'd3, 5'd7, 5'd8, 64'h1, 64'h2, 64'h4, 1'b1, 1'b0, 1'b0);
        #1; n_checks++;
        if (load_use_stall_o !== 1'b0) begin n_fail++; $display("FAIL lus_imm: got %b required 0", load_use_stall_o); end
        id_mem_write_i = 1'b1; id_reg_write_i = 1'b0;
        #1; n_checks++;
        if (load_use_stall_o !== 1'b1) begin n_fail++; $display("FAIL lus_store: got %b required 1", load_use_stall_o); end
        stall_i = 1'b1;
        tick();
        n_checks++;
        if (load_use_stall_o !== 1'b1 || ex_mem_read_o !== 1'b1) begin
            n_fail++; $display("FAIL lus_under_stall: got lus=%b mr=%b required 1 1", load_use_stall_o, ex_mem_read_o);
        end
        stall_i = 1'b0;
        tick();
    endtask

    task automatic test_stall_flush();
        set_idle(); tick();
        id_op(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 64'h1357, 64'h2468, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_id();
            tick();
            n_checks++;
            if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd12 || op_sel_o !== 4'd0 ||
                src1_o !== 64'h1357 || src2_o !== 64'h2468) begin
                n_fail++; $display("FAIL stall_hold%0d: got valid=%b rd=%0d op=%0d src1=%0h src2=%0h required 1 12 0 1357 2468",
                                   c, ex_valid_o, ex_rd_o, op_sel_o, src1_o, src2_o);
            end
        end
        flush_i = 1'b1;
        tick();
        n_checks++;
        if (ex_valid_o !== 1'b0 || ex_reg_write_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_over_stall: got valid=%b rw=%b required 0 0", ex_valid_o, ex_reg_write_o);
        end
        set_idle();
    endtask

    task automatic test_store();
        set_idle(); tick();
        id_op(2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd9, 5'd0, 64'h100, 64'h5, 64'h40, 1'b0, 1'b0, 1'b1);
        tick();
        set_idle();
        memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd9; memwb_result_i = 64'h1234;
        #1; n_checks++;
        if (ex_rs2_data_o !== 64'h1234 || src2_o !== 64'h40 || ex_mem_write_o !== 1'b1) begin
            n_fail++; $display("FAIL store_fwd: got rs2d=%0h src2=%0h mw=%b required 1234 40 1",
                               ex_rs2_data_o, src2_o, ex_mem_write_o);
        end
        tick();
    endtask

    task automatic test_reset_in_stall();
        set_idle(); tick();
        id_op(2'b01, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5, 64'h77, 64'h66, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        stall_i = 1'b1; rst_n = 1'b0;
        tick();
        n_checks++;
        if (ex_valid_o !== 1'b0 || src1_o !== '0 || op_sel_o !== 4'd0 || ex_rd_o !== '0) begin
            n_fail++; $display("FAIL reset_in_stall: got valid=%b src1=%0h op=%0d rd=%0d required 0 0 0 0",
                               ex_valid_o, src1_o, op_sel_o, ex_rd_o);
        end
        stall_i = 1'b0; rst_n = 1'b1;
        tick();
        n_checks++;
        if (ex_valid_o !== 1'b1 || op_sel_o !== 4'd6) begin
            n_fail++; $display("FAIL capture_after_reset: got valid=%b op=%0d required 1 6", ex_valid_o, op_sel_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_id();
            rst_n   = ($urandom_range(0, 49) != 0);
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            exmem_reg_write_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 7));
            exmem_result_i = {$urandom, $urandom};
            memwb_reg_write_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 7));
            memwb_result_i = {$urandom, $urandom};
            #1;
            n_checks++;
            if (load_use_stall_o !== ref_lus()) begin
                n_fail++; $display("FAIL rnd_lus c%0d: got %b required %b", c, load_use_stall_o, ref_lus());
            end
            n_checks++;
            if ({ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, illegal_op_o} !==
                {m.v, m.rw, m.mr, m.mw, m.ill}) begin
                n_fail++; $display("FAIL rnd_ctrl c%0d: got %b required %b", c,
                                   {ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, illegal_op_o},
                                   {m.v, m.rw, m.mr, m.mw, m.ill});
            end
            if (m.v) begin
                n_checks++;
                if (src1_o !== ref_fwd(m.rs1, m.d1) || ex_rs2_data_o !== ref_fwd(m.rs2, m.d2) ||
                    src2_o !== (m.src ? m.imm : ref_fwd(m.rs2, m.d2)) ||
                    op_sel_o !== m.op || ex_rd_o !== m.rd) begin
                    n_fail++; $display("FAIL rnd_data c%0d: got src1=%0h src2=%0h op=%0d rd=%0d required %0h %0h %0d %0d",
                                       c, src1_o, src2_o, op_sel_o, ex_rd_o, ref_fwd(m.rs1, m.d1),
                                       (m.src ? m.imm : ref_fwd(m.rs2, m.d2)), m.op, m.rd);
                end
            end
            tick();
        end
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_store();
        test_reset_in_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand front end for the 64-bit ALU. Captures decoded instruction fields from ID and generates the ALU control code (op_sel). Resolves EX/MEM and MEM/WB forwarding and drives src1/src2/op_sel into the ALU in the following cycle. Also detects load-use hazards and requests an ID stall with bubble insertion.

## Interface
- XLEN, 64, datapath width
- REG_W, 5, register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_W each  register indices
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  register-file reads and immediate
- id_alu_src  in  1  1 selects immediate as src2
- id_alu_op  in  2  00 mem, 01 branch, 10 R/I decode, 11 NOR
- id_funct3  in  3; id_funct7_b5  in  1  instruction funct fields
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- stall  in  1  downstream hold (memory wait)
- flush  in  1  kill EX contents (taken branch)
- exmem_reg_write  in  1; exmem_rd  in  REG_W; exmem_result  in  XLEN
- memwb_reg_write  in  1; memwb_rd  in  REG_W; memwb_result  in  XLEN
- ex_valid  out  1  EX holds a real instruction
- src1, src2  out  XLEN each  ALU operands
- op_sel  out  4  ALU operation code
- ex_rs2_data  out  XLEN  forwarded rs2, used as store data
- ex_rd  out  REG_W; ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- illegal_op  out  1  registered decode error for the EX instruction
- load_use_stall  out  1  ID must hold; combinational

## Operation
- op_sel decode at capture:
  - alu_op 00 -> 2 (ADD); 01 -> 6 (SUB); 11 -> 12 (NOR).
  - alu_op 10 by funct3:
    - 000 -> 6 if funct7_b5 & !alu_src, else 2
    - 111 -> 0
    - 110 -> 1
    - 010 -> 7
    - any other funct3 -> op_sel 2, illegal_op=1
- Forwarding, per operand, combinational on registered ex_rs1/ex_rs2:
  - EX/MEM match (reg_write & rd!=0 & rd==rs) has first priority.
  - MEM/WB match has second priority.
  - Otherwise the registered register-file data is used.
- src2 = ex_alu_src ? ex_imm : forwarded rs2. ex_rs2_data is always forwarded rs2.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | ((!id_alu_src | id_mem_write) & id_rs2==ex_rd)).
- Register update per clock edge, in priority order:
  1. !rst_n -> clear.
  2. flush -> bubble.
  3. stall -> hold every field.
  4. load_use_stall -> bubble.
  5. Otherwise capture ID fields. If id_valid=0, capture a bubble.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and illegal_op are 0. Data fields are don't-care but must not cause writes.

## Timing
- Reset values: every registered output is 0. op_sel is 0, src1/src2/ex_rs2_data are 0, and load_use_stall is 0.
- Latency: ID fields accepted at edge N appear on the outputs after edge N, for exactly one cycle unless stall is asserted.
- flush overrides stall in the same cycle. Reset overrides all.
- While stall=1, outputs are stable except through forwarding inputs. Upstream stages freeze the forwarding sources under the same stall.
- load_use_stall depends on current registers and id_* only, with no path from stall or flush. Under stall it stays asserted.
- A reset in the middle of a stall clears all state. The first instruction after reset is captured on the first edge with rst_n=1.
- rd=x0 never forwards, even when reg_write=1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> every output is 0. First capture happens one edge after release.
- Decode sweep: alu_op=10, funct3=000, funct7_b5=1, alu_src=0, rs1_data=10, rs2_data=3 -> next cycle op_sel=6, src1=10, src2=3.
  - Same with alu_src=1, imm=5 -> op_sel=2, src2=5.
  - funct3=001 -> illegal_op=1, op_sel=2.
- Forwarding priority: ex_rs1=5; exmem (rd=5, we=1, result=0xAA); memwb (rd=5, we=1, result=0xBB) -> src1=0xAA.
  - Drop exmem_reg_write -> src1=0xBB.
  - Set both rd=0 -> src1=registered data.
- Load-use: EX holds a load with rd=7; ID presents add with rs2=7, alu_src=0 -> load_use_stall=1, next EX is a bubble (ex_valid=0).
  - Same case with alu_src=1 and no store -> load_use_stall=0.
- Stall vs flush: stall=1 for 3 cycles -> outputs hold while id_* changes.
  - stall=1 with flush=1 -> bubble on the next edge.
- Stores: mem_write=1, alu_src=1, rs2 forwarded from memwb with 0x1234 -> ex_rs2_data=0x1234, src2=imm.
